mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//   Iterative multiply/divide unit in EX; computes mult/multu/div/divu on rs/rt
//   operands and writes the 64-bit result into the register file's hi/lo pair.
//   Sits directly upstream of the register-file hi/lo registers. Raises busy so
//   hazard logic stalls mfhi/mflo and further mult/div until the result lands.
// PARAMETERS
//   WIDTH   32   operand width; hi/lo are each WIDTH bits
//   CNT_W   6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk          in   1      rising-edge clock
//   rst_n        in   1      synchronous reset, active low
//   start        in   1      launch operation (sampled only when accepting)
//   op           in   2      00 mult, 01 multu, 10 div, 11 divu
//   rs_val       in   WIDTH  multiplicand / dividend
//   rt_val       in   WIDTH  multiplier / divisor
//   cancel       in   1      pipeline flush; abort in-flight operation
//   busy         out  1      operation in flight (RUN or FIX)
//   done         out  1      one-cycle result-valid pulse
//   hilo_we      out  1      hi/lo write enable to register file (== done)
//   hi_out       out  WIDTH  product[63:32] / remainder
//   lo_out       out  WIDTH  product[31:0] / quotient
//   div_by_zero  out  1      set with done when a div/divu had rt_val==0
// BEHAVIOUR
//   - Reset (rst_n==0 at edge): state=IDLE; busy, done, hilo_we, div_by_zero=0;
//     hi_out=lo_out=0; counter=0. Overrides start and cancel.
//   - States: IDLE -> RUN -> FIX -> DONE -> IDLE.
//     IDLE: start=1 latches op, |rs|,|rt| (abs only for signed ops), sign
//       flags; counter=WIDTH-1; -> RUN.
//     RUN: one shift-add (mult) or restoring shift-subtract (div) step per
//       cycle; counter decrements; at counter==0 -> FIX. Exactly WIDTH cycles.
//     FIX: signed mult: negate 2*WIDTH product if signs differ. Signed div:
//       negate quotient if signs differ; remainder takes dividend's sign.
//       Result registered into hi_out/lo_out; -> DONE.
//     DONE: done=hilo_we=1 for exactly this cycle. start=1 here is accepted
//       (back-to-back, -> RUN); else -> IDLE.
//   - Latency: start sampled at edge 0 -> done high in cycle after edge
//     WIDTH+2 (34 cycles for WIDTH=32). busy high in RUN and FIX only.
//   - start ignored while busy (no queueing, no error).
//   - hi_out/lo_out change only on FIX->DONE transition; hold otherwise.
//   - Divide by zero: iteration still runs full length; result lo=all ones,
//     hi=rs_val (unmodified dividend); div_by_zero=1 during done cycle, else 0.
//   - Signed overflow (-2^WIDTH-1 / -1): lo=0x80000000, hi=0, no flag.
//   - cancel=1 in RUN or FIX: -> IDLE next edge, no done/hilo_we, hi/lo hold
//     previous values. cancel in IDLE/DONE: no effect (done pulse completes).
//     cancel and start in same IDLE cycle: cancel wins, nothing launched.
//   - op is decoded only at start; changes during RUN have no effect.
// TESTING
//   1 mult 0x00000003 x 0xFFFFFFFE -> after 34 cycles hi=FFFFFFFF lo=FFFFFFFA,
//     done/hilo_we one cycle, busy high cycles 1..33.
//   2 multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=FFFFFFFE lo=00000001.
//   3 div 0xFFFFFFF9 (-7) / 0x00000002 -> lo=FFFFFFFD hi=FFFFFFFF;
//     divu 0x00000064 / 0x00000007 -> lo=0000000E hi=00000002.
//   4 divu 0x12345678 / 0 -> lo=FFFFFFFF hi=12345678, div_by_zero=1 with done.
//   5 start mult, cancel at cycle 10 -> no done in next 40 cycles, hi/lo keep
//     prior result; start pulsed at cycle 5 also ignored (busy).
//   6 rst_n=0 at cycle 20 of a div -> all outputs 0 next edge; back-to-back
//     start in DONE cycle yields second done exactly 34 cycles later.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Multiply/divide unit bus interface.
//   master : issuing side (EX control) drives start/op/operands/cancel
//   slave  : mult_div_unit, returns busy/done/hilo_we/hi/lo/div_by_zero
interface mult_div_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             cancel;
   logic             busy;
   logic             done;
   logic             hilo_we;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;
   logic             div_by_zero;

   modport master (
      output start, op, rs_val, rt_val, cancel,
      input  busy, done, hilo_we, hi_out, lo_out, div_by_zero
   );

   modport slave (
      input  start, op, rs_val, rt_val, cancel,
      output busy, done, hilo_we, hi_out, lo_out, div_by_zero
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit (mult, multu, div, divu) feeding hi/lo.
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   bus        : start/op/rs_val/rt_val/cancel in; busy/done/hilo_we/
//                hi_out/lo_out/div_by_zero out (see mult_div_unit_if)
// One shift-add or restoring shift-subtract step per RUN cycle on magnitudes;
// signs are applied in FIX. Result visible in DONE, one cycle later.
module mult_div_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input logic           clk,
   input logic           rst_n,
   mult_div_unit_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic [1:0]           op_q;
   logic                 neg_a_q, neg_b_q, zero_q;
   // hi half: partial product / remainder; lo half: multiplier / quotient
   logic [2*WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]     b_q;
   logic [WIDTH-1:0]     hi_q, lo_q;

   logic                 launch, step, load_res;
   logic                 sgn_in;
   logic [WIDTH-1:0]     abs_rs, abs_rt;
   logic [WIDTH:0]       sum, shifted, diff;
   logic [2*WIDTH-1:0]   acc_step, prod_fix;
   logic [WIDTH-1:0]     quo_fix, rem_fix, fix_hi, fix_lo;

   // FSM next state. cancel also suppresses a launch in DONE: a flushed
   // instruction must not start a new operation.
   always_comb begin
      state_d  = state_q;
      launch   = 1'b0;
      step     = 1'b0;
      load_res = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start && !bus.cancel) begin
               launch  = 1'b1;
               state_d = StRun;
            end
         end
         StRun: begin
            if (bus.cancel) begin
               state_d = StIdle;
            end else begin
               step = 1'b1;
               if (cnt_q == '0) state_d = StFix;
            end
         end
         StFix: begin
            if (bus.cancel) begin
               state_d = StIdle;
            end else begin
               load_res = 1'b1;
               state_d  = StDone;
            end
         end
         StDone: begin
            if (bus.start && !bus.cancel) begin
               launch  = 1'b1;
               state_d = StRun;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Operand magnitudes; op[0]==0 means signed.
   always_comb begin
      sgn_in = !bus.op[0];
      abs_rs = (sgn_in && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
      abs_rt = (sgn_in && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;
   end

   // One iteration step.
   always_comb begin
      sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
      shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      diff     = shifted - {1'b0, b_q};
      acc_step = {sum, acc_q[WIDTH-1:1]};
      if (op_q[1]) begin
         // Borrow clear: subtract succeeds, quotient bit 1. With b==0 this
         // always succeeds, giving all-ones quotient and remainder == |rs|.
         if (!diff[WIDTH]) acc_step = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         else              acc_step = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
   end

   // Sign fix-up. For div-by-zero the remainder sign fix restores rs_val.
   always_comb begin
      prod_fix = (!op_q[0] && (neg_a_q ^ neg_b_q)) ? -acc_q : acc_q;
      quo_fix  = acc_q[WIDTH-1:0];
      if (!op_q[0] && (neg_a_q ^ neg_b_q)) quo_fix = -acc_q[WIDTH-1:0];
      if (zero_q) quo_fix = '1;
      rem_fix  = acc_q[2*WIDTH-1:WIDTH];
      if (!op_q[0] && neg_a_q) rem_fix = -acc_q[2*WIDTH-1:WIDTH];
      fix_hi   = op_q[1] ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
      fix_lo   = op_q[1] ? quo_fix : prod_fix[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_q    <= '0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         zero_q  <= 1'b0;
         acc_q   <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         if (launch) begin
            op_q    <= bus.op;
            neg_a_q <= sgn_in && bus.rs_val[WIDTH-1];
            neg_b_q <= sgn_in && bus.rt_val[WIDTH-1];
            zero_q  <= bus.op[1] && (bus.rt_val == '0);
            acc_q   <= {{WIDTH{1'b0}}, abs_rs};
            b_q     <= abs_rt;
            cnt_q   <= CNT_W'(WIDTH - 1);
         end else if (step) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q - CNT_W'(1);
         end
         if (load_res) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
         end
      end
   end

   always_comb begin
      bus.busy        = (state_q == StRun) || (state_q == StFix);
      bus.done        = (state_q == StDone);
      bus.hilo_we     = (state_q == StDone);
      bus.div_by_zero = (state_q == StDone) && zero_q;
      bus.hi_out      = hi_q;
      bus.lo_out      = lo_q;
   end
endmodule
